// File: rtl/mem_access_seq_pkg.sv
// Shared opcode constants, FSM encoding and opcode helpers for the load/store path.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_e;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // Halfword ops need an even address, word ops a word-aligned one.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return (a != 2'b00);
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_seq_load_extend.sv
// Byte/halfword lane select plus sign/zero extension of a loaded word.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend according to the opcode.
  always_comb begin
    byte_sel = data_i[7:0];
    case (addr_i)
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      2'd3:    byte_sel = data_i[31:24];
      default: byte_sel = data_i[7:0];
    endcase
    half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];
    data_o   = data_i;
    case (op_i)
      OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data_o = {24'h0, byte_sel};
      OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data_o = {16'h0, half_sel};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer: one access per handshake, sub-word stores
// done as read-modify-write against a byte-enable-less word memory.
module mem_access_seq
  import mem_pkg::*;
#(
  parameter int AW          = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [5:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          resp_valid,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  localparam logic [31:0] TO_LAST = 32'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [5:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rd_q, rd_d;
  logic [31:0]   mwd_q, mwd_d;
  logic          err_q, err_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   merged;
  logic [31:0]   ext_data;
  logic          timeout;

  load_extend u_ext (
    .data_i (rd_q),
    .op_i   (op_q),
    .addr_i (addr_q[1:0]),
    .data_o (ext_data)
  );

  // Address and write data come straight from registers, so they hold while mem_en is up.
  assign mem_addr  = {addr_q[AW-1:2], 2'b00};
  assign mem_wdata = mwd_q;
  assign timeout   = (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST);

  // Splice the store data into the word just read back.
  always_comb begin
    merged = mem_rdata;
    if (op_q == OP_SB) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    mwd_d      = mwd_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    rdata      = 32'h0;
    err        = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        cnt_d = 32'h0;
        if ((!is_load(op_q) && !is_store(op_q)) || is_misaligned(op_q, addr_q[1:0])) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (op_q == OP_SW) begin
          mwd_d   = wdata_q;
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        mem_en = 1'b1;
        if (mem_ack) begin
          rd_d  = mem_rdata;
          cnt_d = 32'h0;
          if (is_load(op_q)) begin
            state_d = ST_DONE;
          end else begin
            mwd_d   = merged;
            state_d = ST_WR;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_WR: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        if (mem_ack) begin
          state_d = ST_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        err        = err_q;
        rdata      = (is_load(op_q) && !err_q) ? ext_data : 32'h0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 6'h0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rd_q    <= 32'h0;
      mwd_q   <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      mwd_q   <= mwd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed scoreboard bench for mem_access_seq.
module tb_mem_access_seq;
  import mem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          en_cyc;
    logic [31:0] maddr;
    logic        chk_wr;
    logic [31:0] mwdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [5:0]  op = 6'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        resp_valid, err;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  logic        t_req_valid = 1'b0, t_req_ready, t_resp_valid, t_err, t_mem_en, t_mem_we;
  logic [31:0] t_rdata, t_mem_addr, t_mem_wdata;
  logic [31:0] t_mem_rdata = 32'h0;
  logic        t_mem_ack = 1'b0;

  always #5 clk = ~clk;

  mem_access_seq #(.AW(32), .MEM_TIMEOUT(0)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .addr(addr), .wdata(wdata), .resp_valid(resp_valid),
    .rdata(rdata), .err(err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  mem_access_seq #(.AW(32), .MEM_TIMEOUT(4)) u_to (
    .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .op(op), .addr(addr), .wdata(wdata), .resp_valid(t_resp_valid),
    .rdata(t_rdata), .err(t_err), .mem_en(t_mem_en), .mem_we(t_mem_we),
    .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_rdata(t_mem_rdata),
    .mem_ack(t_mem_ack)
  );

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_vec = 0, n_bad = 0;
  int          cyc = 0, acc_cyc = 0, en_seen = 0, ack_delay = 1, rcnt = 0;
  int          t_en = 0;
  bit          t_got = 1'b0;
  logic [31:0] last_maddr = 32'h0, last_wword = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic e, input int lat, input int en,
                              input logic [31:0] ma, input logic cw, input logic [31:0] mw);
    exp_t x;
    x.rdata = rd; x.err = e; x.lat = lat; x.en_cyc = en;
    x.maddr = ma; x.chk_wr = cw; x.mwdata = mw;
    return x;
  endfunction

  // Memory responder: ack arrives ack_delay cycles after mem_en first shows.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_en && !rst) begin
        if (rcnt == ack_delay) begin
          mem_ack = 1'b1;
          rcnt    = 0;
        end else begin
          rcnt++;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // Monitor: tracks accept time and memory activity, pops the scoreboard on each response.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        acc_cyc = cyc;
        en_seen = 0;
      end
      if (mem_en) begin
        en_seen++;
        last_maddr = mem_addr;
        if (mem_we) last_wword = mem_wdata;
      end
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
        end else begin
          mon_e = sbq.pop_front();
          chk("rdata", rdata, mon_e.rdata);
          chk("err", {31'h0, err}, {31'h0, mon_e.err});
          chk("latency", cyc - acc_cyc + 1, mon_e.lat);
          chk("mem_en_cycles", en_seen, mon_e.en_cyc);
          if (mon_e.en_cyc > 0) chk("mem_addr", last_maddr, mon_e.maddr);
          if (mon_e.chk_wr) chk("mem_wdata", last_wword, mon_e.mwdata);
        end
      end
    end
  end

  // Monitor for the timeout-enabled instance, whose memory never acks.
  always @(negedge clk) begin
    if (!rst) begin
      if (t_mem_en) t_en++;
      if (t_resp_valid) begin
        t_got = 1'b1;
        chk("to_err", {31'h0, t_err}, 32'h1);
        chk("to_rdata", t_rdata, 32'h0);
        chk("to_mem_en_at_resp", {31'h0, t_mem_en}, 32'h0);
        chk("to_wait_cycles", t_en, 4);
      end
    end
  end

  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] mword, input int dly, input exp_t e, input bit expect_resp);
    int n;
    n = 0;
    mem_rdata = mword;
    ack_delay = dly;
    if (expect_resp) sbq.push_back(e);
    @(negedge clk);
    op = o; addr = a; wdata = w; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL resp_timeout: got %0d responses outstanding expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  exp_t none;

  initial begin
    int n;
    none = mk(32'h0, 1'b0, 0, 0, 32'h0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    issue(OP_LB,  32'h1003, 32'h0, 32'h80123456, 1, mk(32'hFFFFFF80, 0, 5, 2, 32'h1000, 0, 0), 1); drain();
    issue(OP_LBU, 32'h1003, 32'h0, 32'h80123456, 1, mk(32'h00000080, 0, 5, 2, 32'h1000, 0, 0), 1); drain();
    issue(OP_LHU, 32'h2002, 32'h0, 32'hBEEF1234, 1, mk(32'h0000BEEF, 0, 5, 2, 32'h2000, 0, 0), 1); drain();
    issue(OP_LH,  32'h2002, 32'h0, 32'hBEEF1234, 1, mk(32'hFFFFBEEF, 0, 5, 2, 32'h2000, 0, 0), 1); drain();
    issue(OP_LH,  32'h2000, 32'h0, 32'hBEEF1234, 1, mk(32'h00001234, 0, 5, 2, 32'h2000, 0, 0), 1); drain();
    issue(OP_SB,  32'h3001, 32'hAA, 32'h11223344, 1, mk(32'h0, 0, 7, 4, 32'h3000, 1, 32'h1122AA44), 1); drain();
    issue(OP_SH,  32'h3002, 32'h5566, 32'h11223344, 1, mk(32'h0, 0, 7, 4, 32'h3000, 1, 32'h55663344), 1); drain();
    issue(OP_SW,  32'h4004, 32'hCAFEF00D, 32'h0, 1, mk(32'h0, 0, 5, 2, 32'h4004, 1, 32'hCAFEF00D), 1); drain();
    issue(OP_SW,  32'h4002, 32'h12345678, 32'h0, 1, mk(32'h0, 1, 3, 0, 32'h0, 0, 0), 1); drain();
    issue(OP_LH,  32'h4001, 32'h0, 32'hFFFFFFFF, 1, mk(32'h0, 1, 3, 0, 32'h0, 0, 0), 1); drain();
    issue(6'h2A,  32'h4000, 32'h0, 32'hFFFFFFFF, 1, mk(32'h0, 1, 3, 0, 32'h0, 0, 0), 1); drain();
    issue(OP_LW,  32'h6000, 32'h0, 32'hDEADBEEF, 6, mk(32'hDEADBEEF, 0, 10, 7, 32'h6000, 0, 0), 1); drain();

    // Reset in the middle of a read: no response, sequencer back to idle.
    issue(OP_LW, 32'h6100, 32'h0, 32'h0, 10000, none, 0);
    n = 0;
    while (!mem_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_reached", {31'h0, mem_en}, 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("abort_mem_en", {31'h0, mem_en}, 32'h0);
    repeat (5) @(negedge clk);

    // Timeout on a store to a memory that never acks.
    t_en = 0;
    t_got = 1'b0;
    op = OP_SW; addr = 32'h5000; wdata = 32'h0BADF00D;
    t_req_valid = 1'b1;
    @(posedge clk);
    #1 t_req_valid = 1'b0;
    n = 0;
    while (!t_got && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!t_got) begin
      n_vec++;
      n_bad++;
      $display("FAIL to_resp: got no response expected err response");
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
